// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding and architectural fetch addresses.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY     = 32'h0000_4180;

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory request/acknowledge bundle between the fetch sequencer and imem.
interface fetch_seq_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_seq.sv
// F-stage sequencer: owns the fetch PC, drives imem requests, applies delayed
// D-stage redirects (after the delay slot) and immediate M-stage exception redirects.
module fetch_seq
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fd_ready,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   input  logic        exc_valid,
   input  logic [31:0] exc_target,
   fetch_seq_if.master imem,
   output logic        valid_f,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ibuf_q, ibuf_d;
   logic         rp_valid_q, rp_valid_d;
   logic [31:0]  rp_target_q, rp_target_d;
   logic [31:0]  stale_q, stale_d;
   logic         handoff;

   always_comb begin
      imem.req  = 1'b0;
      imem.addr = pc_q;
      valid_f   = 1'b0;
      instr_f   = imem.rdata;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               imem.req = 1'b1;
               valid_f  = imem.ack & ~exc_valid;
            end
            HOLD: begin
               valid_f = ~exc_valid;
               instr_f = ibuf_q;
            end
            DRAIN: begin
               // The abandoned request must stay stable until imem acks it.
               imem.req  = 1'b1;
               imem.addr = stale_q;
            end
            default: ;
         endcase
      end
   end

   assign pc_f    = pc_q;
   assign handoff = valid_f & fd_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ibuf_d      = ibuf_q;
      rp_valid_d  = rp_valid_q;
      rp_target_d = rp_target_q;
      stale_d     = stale_q;

      if (exc_valid) begin
         pc_d       = exc_target;
         rp_valid_d = 1'b0;
         if (state_q == HOLD || imem.ack) begin
            state_d = FETCH;
         end else begin
            state_d = DRAIN;
            if (state_q == FETCH) stale_d = pc_q;
         end
      end else if (handoff) begin
         // The instruction leaving now is the delay slot if a redirect is live.
         if (redir_valid)     pc_d = redir_target;
         else if (rp_valid_q) pc_d = rp_target_q;
         else                 pc_d = pc_q + 32'd4;
         rp_valid_d = 1'b0;
         state_d    = FETCH;
      end else begin
         if (redir_valid) begin
            rp_valid_d  = 1'b1;
            rp_target_d = redir_target;
         end
         case (state_q)
            FETCH: if (imem.ack) begin
               state_d = HOLD;
               ibuf_d  = imem.rdata;
            end
            DRAIN: if (imem.ack) state_d = FETCH;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= PC_RESET;
         ibuf_q      <= 32'd0;
         rp_valid_q  <= 1'b0;
         rp_target_q <= 32'd0;
         stale_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ibuf_q      <= ibuf_d;
         rp_valid_q  <= rp_valid_d;
         rp_target_q <= rp_target_d;
         stale_q     <= stale_d;
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus a randomized run
// scored against a transaction-level model of the delivered instruction stream.
module tb_fetch_seq;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        fd_ready;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        exc_valid;
   logic [31:0] exc_target;
   logic        valid_f;
   logic [31:0] instr_f;
   logic [31:0] pc_f;

   fetch_seq_if bus ();

   fetch_seq #(.PC_RESET(32'h0000_3000)) dut (
      .clk          (clk),
      .reset        (reset),
      .fd_ready     (fd_ready),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .exc_valid    (exc_valid),
      .exc_target   (exc_target),
      .imem         (bus.master),
      .valid_f      (valid_f),
      .instr_f      (instr_f),
      .pc_f         (pc_f)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // next-cycle input shadows; pulses are cleared after each applied cycle
   logic        nx_reset = 1'b1;
   logic        nx_fd_ready = 1'b1;
   logic        nx_redir = 1'b0;
   logic [31:0] nx_rtgt = 32'd0;
   logic        nx_exc = 1'b0;
   logic [31:0] nx_etgt = 32'd0;

   // imem model state
   int          lat_mode = 0;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   int          m_lat = 0;
   logic        prev_ack = 1'b0;
   logic        prev_reset = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic step();
      @(posedge clk);
      if (prev_reset)    m_busy = 1'b0;
      else if (prev_ack) m_busy = 1'b0;
      else if (m_busy)   m_cnt++;
      #1;
      reset        = nx_reset;
      fd_ready     = nx_fd_ready;
      redir_valid  = nx_redir;
      redir_target = nx_rtgt;
      exc_valid    = nx_exc;
      exc_target   = nx_etgt;
      nx_redir = 1'b0;
      nx_exc   = 1'b0;
      #1;
      if (bus.req) begin
         if (!m_busy) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         end
         bus.ack   = (m_cnt == m_lat);
         bus.rdata = bus.ack ? mem_word(bus.addr) : 32'hDEAD_BEEF;
      end else begin
         bus.ack   = 1'b0;
         bus.rdata = 32'hDEAD_BEEF;
      end
      prev_ack   = bus.ack;
      prev_reset = reset;
      #1;
   endtask

   task automatic do_reset();
      nx_reset = 1'b1;
      step();
      step();
      nx_reset = 1'b0;
   endtask

   task automatic test_reset();
      lat_mode    = 0;
      nx_fd_ready = 1'b1;
      nx_reset    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (bus.req !== 1'b0 || valid_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req=%b valid_f=%b required 0/0", bus.req, valid_f);
         end
      end
      nx_reset = 1'b0;
      step();
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3000) begin
         n_fail++;
         $display("FAIL reset_first_req: req=%b addr=%h required 1/00003000", bus.req, bus.addr);
      end
   endtask

   task automatic test_zero_wait_and_redirect();
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'h0000_3004;
      exp_addr[1] = 32'h0000_3008;
      exp_addr[2] = 32'h0000_3100;
      exp_addr[3] = 32'h0000_3104;
      n_checks++;
      if (valid_f !== 1'b1 || instr_f !== mem_word(32'h0000_3000)) begin
         n_fail++;
         $display("FAIL zw_first: valid_f=%b instr=%h required 1/%h", valid_f, instr_f, mem_word(32'h0000_3000));
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            nx_redir = 1'b1;
            nx_rtgt  = 32'h0000_3100;
         end
         step();
         n_checks++;
         if (bus.addr !== exp_addr[i] || valid_f !== 1'b1 || pc_f !== exp_addr[i]) begin
            n_fail++;
            $display("FAIL zw_seq%0d: addr=%h valid_f=%b pc_f=%h required %h/1", i, bus.addr, valid_f, pc_f, exp_addr[i]);
         end
      end
   endtask

   task automatic test_redirect_stall();
      lat_mode    = 0;
      nx_fd_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      nx_fd_ready = 1'b0;
      step();
      n_checks++;
      if (pc_f !== 32'h0000_300C || valid_f !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_fetch: pc_f=%h valid_f=%b required 0000300c/1", pc_f, valid_f);
      end
      nx_redir = 1'b1;
      nx_rtgt  = 32'h0000_3200;
      step();
      n_checks++;
      if (bus.req !== 1'b0 || valid_f !== 1'b1 || instr_f !== mem_word(32'h0000_300C)) begin
         n_fail++;
         $display("FAIL stall_hold: req=%b valid_f=%b instr=%h required 0/1/%h", bus.req, valid_f, instr_f, mem_word(32'h0000_300C));
      end
      nx_fd_ready = 1'b1;
      step();
      n_checks++;
      if (pc_f !== 32'h0000_300C || valid_f !== 1'b1 || instr_f !== mem_word(32'h0000_300C)) begin
         n_fail++;
         $display("FAIL stall_delay_slot: pc_f=%h valid_f=%b instr=%h required 0000300c/1", pc_f, valid_f, instr_f);
      end
      step();
      n_checks++;
      if (bus.addr !== 32'h0000_3200 || bus.req !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_target: addr=%h req=%b required 00003200/1", bus.addr, bus.req);
      end
   endtask

   task automatic test_exc_drain();
      lat_mode    = 3;
      nx_fd_ready = 1'b1;
      do_reset();
      step();
      nx_exc  = 1'b1;
      nx_etgt = EXC_ENTRY;
      step();
      n_checks++;
      if (valid_f !== 1'b0 || bus.ack !== 1'b0) begin
         n_fail++;
         $display("FAIL exc_issue: valid_f=%b ack=%b required 0/0", valid_f, bus.ack);
      end
      step();
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3000 || valid_f !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_wait: req=%b addr=%h valid_f=%b required 1/00003000/0", bus.req, bus.addr, valid_f);
      end
      step();
      n_checks++;
      if (bus.ack !== 1'b1 || valid_f !== 1'b0 || bus.addr !== 32'h0000_3000) begin
         n_fail++;
         $display("FAIL drain_stale_ack: ack=%b valid_f=%b addr=%h required 1/0/00003000", bus.ack, valid_f, bus.addr);
      end
      step();
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== EXC_ENTRY) begin
         n_fail++;
         $display("FAIL drain_refetch: req=%b addr=%h required 1/%h", bus.req, bus.addr, EXC_ENTRY);
      end
   endtask

   task automatic test_exc_beats_redirect();
      lat_mode    = 0;
      nx_fd_ready = 1'b1;
      do_reset();
      step();
      nx_exc   = 1'b1;
      nx_etgt  = 32'h0000_3040;
      nx_redir = 1'b1;
      nx_rtgt  = 32'h0000_3300;
      step();
      n_checks++;
      if (valid_f !== 1'b0) begin
         n_fail++;
         $display("FAIL excredir_flush: valid_f=%b required 0", valid_f);
      end
      step();
      n_checks++;
      if (bus.addr !== 32'h0000_3040 || valid_f !== 1'b1) begin
         n_fail++;
         $display("FAIL excredir_epc: addr=%h valid_f=%b required 00003040/1", bus.addr, valid_f);
      end
      step();
      n_checks++;
      if (bus.addr !== 32'h0000_3044) begin
         n_fail++;
         $display("FAIL excredir_no_pending: addr=%h required 00003044", bus.addr);
      end
   endtask

   task automatic test_reset_drain();
      lat_mode    = 3;
      nx_fd_ready = 1'b1;
      do_reset();
      step();
      nx_exc  = 1'b1;
      nx_etgt = EXC_ENTRY;
      step();
      nx_reset = 1'b1;
      step();
      n_checks++;
      if (bus.req !== 1'b0 || valid_f !== 1'b0) begin
         n_fail++;
         $display("FAIL rstdrain_idle: req=%b valid_f=%b required 0/0", bus.req, valid_f);
      end
      nx_reset = 1'b0;
      step();
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3000) begin
         n_fail++;
         $display("FAIL rstdrain_restart: req=%b addr=%h required 1/00003000", bus.req, bus.addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic        pend;
      logic [31:0] ptgt;
      logic        r, e, hold_prev;
      logic [31:0] rt, et, addr_prev;
      int          handoffs;
      lat_mode    = -1;
      nx_fd_ready = 1'b1;
      do_reset();
      exp_pc    = PC_RESET_ADDR;
      pend      = 1'b0;
      ptgt      = 32'd0;
      hold_prev = 1'b0;
      addr_prev = 32'd0;
      handoffs  = 0;
      for (int c = 0; c < 1500; c++) begin
         nx_fd_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) begin
            nx_redir = 1'b1;
            nx_rtgt  = $urandom & 32'hFFFF_FFFC;
         end
         if ($urandom_range(0, 31) == 0) begin
            nx_exc  = 1'b1;
            nx_etgt = ($urandom_range(0, 1) == 0) ? EXC_ENTRY : ($urandom & 32'hFFFF_FFFC);
         end
         r  = nx_redir;
         rt = nx_rtgt;
         e  = nx_exc;
         et = nx_etgt;
         step();
         if (hold_prev) begin
            n_checks++;
            if (bus.req !== 1'b1 || bus.addr !== addr_prev) begin
               n_fail++;
               $display("FAIL rnd_req_stable c%0d: req=%b addr=%h required 1/%h", c, bus.req, bus.addr, addr_prev);
            end
         end
         hold_prev = bus.req & ~bus.ack;
         addr_prev = bus.addr;
         if (e) begin
            n_checks++;
            if (valid_f !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_exc_flush c%0d: valid_f=%b required 0", c, valid_f);
            end
            exp_pc = et;
            pend   = 1'b0;
         end else if (valid_f === 1'b1 && fd_ready) begin
            handoffs++;
            n_checks++;
            if (pc_f !== exp_pc || instr_f !== mem_word(exp_pc)) begin
               n_fail++;
               $display("FAIL rnd_handoff c%0d: pc_f=%h instr=%h required %h/%h", c, pc_f, instr_f, exp_pc, mem_word(exp_pc));
            end
            exp_pc = r ? rt : (pend ? ptgt : exp_pc + 32'd4);
            pend   = 1'b0;
         end else if (r) begin
            pend = 1'b1;
            ptgt = rt;
         end
      end
      n_checks++;
      if (handoffs < 200) begin
         n_fail++;
         $display("FAIL rnd_progress: handoffs=%0d required >=200", handoffs);
      end
   endtask

   initial begin
      reset        = 1'b1;
      fd_ready     = 1'b1;
      redir_valid  = 1'b0;
      redir_target = 32'd0;
      exc_valid    = 1'b0;
      exc_target   = 32'd0;
      bus.ack      = 1'b0;
      bus.rdata    = 32'd0;
      test_reset();
      test_zero_wait_and_redirect();
      test_redirect_stall();
      test_exc_drain();
      test_exc_beats_redirect();
      test_reset_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer for the pipelined MIPS core: owns the F-stage PC register and sequences instruction-memory requests against a variable-latency `imem` handshake. It applies D-stage control-transfer redirects after the branch delay slot, and applies M-stage exception/eret redirects immediately with flush. It sits between the next-PC computation (target supplied by D), the instruction memory, and the F/D pipeline register.

## Interface
Parameters:
- `PC_RESET`, default `32'h0000_3000`: first fetch address after reset.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `fd_ready`  in  1  F/D register can accept an instruction this cycle (`!stall` from the hazard unit).
- `redir_valid`  in  1  one-cycle pulse; a taken branch, `j`, `jal` or `jr` leaves D this cycle.
- `redir_target`  in  32  target for `redir_valid`.
- `exc_valid`  in  1  exception or eret redirect from M; flushes F.
- `exc_target`  in  32  `32'h0000_4180` or EPC, selected upstream.
- `imem_req`  out  1  fetch request; held high until acked.
- `imem_addr`  out  32  fetch address (= `pc_f`).
- `imem_ack`  in  1  `imem_rdata` valid; may rise in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `valid_f`  out  1  `instr_f`/`pc_f` are presented to F/D.
- `instr_f`  out  32  fetched instruction.
- `pc_f`  out  32  PC of the fetch in progress or presented.

## Operation
- **Registers:**
  - `pc`: 32 bits.
  - `state`: FETCH / HOLD / DRAIN.
  - `ibuf`: 32 bits.
  - `rp_valid` and `rp_target`: pending redirect.
- **FETCH:**
  - `imem_req=1`.
  - `valid_f = imem_ack & !exc_valid`.
  - `instr_f = imem_rdata`.
- **HOLD:**
  - `imem_req=0`.
  - `valid_f = !exc_valid`.
  - `instr_f = ibuf`.
- **DRAIN:**
  - `imem_req=1`, `imem_addr` keeps the stale address.
  - `valid_f=0`.
- **Handoff** means `valid_f & fd_ready` at a posedge.
  - `pc <= (redir_valid | rp_valid) ? (redir_valid ? redir_target : rp_target) : pc+4`.
  - Clear `rp_valid`.
  - Next state is FETCH.
- **Delay slot:** the handoff in the same cycle as `redir_valid`, or the first handoff after it, is the delay slot at `PC_D+4`. It is delivered unchanged; only the fetch after it uses the target.
- **`redir_valid` without handoff:** latch `rp_target <= redir_target`, `rp_valid <= 1`. A second redirect while pending overwrites (architecturally undefined).
- **FETCH transitions:**
  - `imem_ack & !fd_ready` → HOLD, with `ibuf <= imem_rdata`.
  - No ack → stay in FETCH.
- **HOLD transitions:** `fd_ready` → handoff; otherwise stay.
- **`exc_valid` (highest priority, any state):**
  - `pc <= exc_target`, `rp_valid <= 0`, buffered instruction dropped.
  - Next state is FETCH if no request is outstanding (HOLD, or FETCH/DRAIN with `imem_ack` this cycle).
  - Otherwise next state is DRAIN.
- **DRAIN:** on `imem_ack`, discard `imem_rdata` → FETCH. Any `exc_valid` in DRAIN only updates `pc`.
- `pc` increment wraps modulo 2^32. No alignment check here; AdEL on fetch is detected downstream from `pc_f`.

## Timing
- **Reset values:**
  - `state=FETCH`, `pc=PC_RESET`, `rp_valid=0`, `ibuf=0`.
  - While `reset=1`: `imem_req=0`, `valid_f=0`.
  - First request at `PC_RESET` in the first cycle after reset deasserts.
- **Throughput:** zero-wait memory (ack same cycle) with `fd_ready=1` gives one instruction per cycle. Combinational path `imem_ack` → `valid_f`; no added latency.
- **N-cycle memory:** N+1 cycles per instruction.
- **Exception latency:** the first fetch at `exc_target` is requested the cycle after `exc_valid`, or the cycle after the stale ack when draining.
- **Reset mid-DRAIN or mid-FETCH:** abandons the request; `imem` shares `reset` and drops it.

## Structure
- The shared package `cpu_pkg` holds:
  - the `fetch_state_t` enum (FETCH, HOLD, DRAIN);
  - `PC_RESET_ADDR = 32'h0000_3000`;
  - `EXC_ENTRY = 32'h0000_4180` (used upstream).
- Single module; no sub-module. `ibuf` and the pending-redirect pair are plain registers.

## Test plan
- **Reset, zero-wait memory, `fd_ready=1`:** `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles; `valid_f=1` each cycle.
- **Redirect same cycle as delay-slot handoff:** `redir_valid` with target 0x3100 in the cycle 0x3008 is handed off → next `imem_addr` is 0x3100.
- **Redirect during stall:** `redir_valid` (0x3200) while `fd_ready=0`, `pc_f=0x300C` buffered in HOLD → 0x300C is delivered when `fd_ready` rises; next fetch is 0x3200.
- **Exception with outstanding fetch:** 3-cycle memory, `exc_valid` (0x4180) one cycle after a request → DRAIN; stale ack discarded with `valid_f=0`; next `imem_addr` is 0x4180.
- **Exception beats redirect:** `exc_valid` (EPC 0x3040) and `redir_valid` (0x3300) in the same cycle → fetch 0x3040; `rp_valid=0`; 0x3300 is never fetched.
- **Reset mid-DRAIN:** `reset` pulsed while in DRAIN → `imem_req=0` during reset; fetch restarts at 0x3000.
